// File: rtl/serial_arith_defs.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_defs;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational full adder built from two half adders.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0, c0, c1;

  halfAdder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  halfAdder u_ha1 (
    .a     (s0),
    .b     (cin),
    .sum   (sum),
    .carry (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/halfAdder.sv
// Single-bit half adder primitive.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles,
// with a start/done handshake and result held until the next accepted start.
module serial_adder_ctrl
  import serial_arith_defs::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic [WIDTH:0]   sum_shift;

  full_adder_cell u_fa (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // New bit enters at the MSB; the LSB falls off. Works for WIDTH == 1 too.
  assign sum_shift = {fa_s, sum_q};

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d   = sum_shift[WIDTH:1];
        carry_d = fa_c;
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
